// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8-bit frames with a parity bit, assembled into 4-byte {cmd, addr_h, addr_l, data} packets.
// A packet whose cmd is CMD_WR drives a one-cycle reg_wr. Define PARITY_CHK_EN to reject bytes with bad (even) parity.
module uart_cmd_rx #(
  parameter int          BAUD_DIV = 868,
  parameter int          TIMEOUT  = 100000,
  parameter logic [7:0]  CMD_WR   = 8'hB0
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        reg_wr,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        rx_byte_vld,
  output logic [7:0]  rx_byte,
  output logic        err_frame,
  output logic        err_parity,
  output logic        err_cmd
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} bit_st_t;
  typedef enum logic [1:0] {P_CMD, P_AH, P_AL, P_DAT} pkt_st_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  // ---- line synchroniser and falling-edge detect ----
  logic [1:0] rx_sync;
  logic       rx_d;
  logic       rx_s;
  logic       fall;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_d    <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_d    <= rx_sync[1];
    end
  end

  assign rx_s = rx_sync[1];
  // An edge needs a high sample first, so a held-low break cannot retrigger.
  assign fall = rx_d & ~rx_s;

  // ---- bit FSM ----
  bit_st_t       bit_st, bit_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_val;
  logic          cnt_ld;
  logic          tick;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          start_det;
  logic          smp_data;
  logic          byte_done;

  assign tick = (cnt == CW'(1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) bit_st <= IDLE;
    else        bit_st <= bit_nxt;
  end

  always_comb begin
    bit_nxt   = bit_st;
    cnt_ld    = 1'b0;
    cnt_val   = FULL;
    start_det = 1'b0;
    smp_data  = 1'b0;
    byte_done = 1'b0;
    case (bit_st)
      IDLE: if (fall) begin
        bit_nxt   = START;
        cnt_ld    = 1'b1;
        cnt_val   = HALF;
        start_det = 1'b1;
      end
      START: if (tick) begin
        if (rx_s) bit_nxt = IDLE;
        else begin
          bit_nxt = DATA;
          cnt_ld  = 1'b1;
        end
      end
      DATA: if (tick) begin
        smp_data = 1'b1;
        cnt_ld   = 1'b1;
        if (idx == 3'd7) bit_nxt = PARITY;
      end
      PARITY: if (tick) begin
        cnt_ld  = 1'b1;
        bit_nxt = STOP;
      end
      STOP: if (tick) begin
        byte_done = 1'b1;
        bit_nxt   = IDLE;
      end
      default: bit_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (cnt_ld)          cnt <= cnt_val;
      else if (cnt != '0)  cnt <= cnt - CW'(1);
      if (bit_st == START) idx <= '0;
      else if (smp_data)   idx <= idx + 3'd1;
      if (smp_data)        shift[idx] <= rx_s;
    end
  end

  // ---- byte verdict at the stop sample ----
  logic par_fail;

`ifdef PARITY_CHK_EN
  logic par_bit;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                          par_bit <= 1'b0;
    else if (bit_st == PARITY && tick)   par_bit <= rx_s;
  end

  assign par_fail = par_bit ^ (^shift);
`else
  assign par_fail = 1'b0;
`endif

  logic accept, ferr, perr, drop;

  assign accept = byte_done & rx_s & ~par_fail;
  assign ferr   = byte_done & ~rx_s;
  assign perr   = byte_done & par_fail;
  assign drop   = ferr | perr;

  // ---- packet FSM and inter-byte timeout ----
  pkt_st_t       pkt_st, pkt_nxt;
  logic [TW-1:0] to_cnt;
  logic          to_run;
  logic          to_hit;

  assign to_run = (pkt_st != P_CMD) && (bit_st == IDLE);
  // A start edge in the expiry cycle wins, keeping the partial packet.
  assign to_hit = to_run && !start_det && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) pkt_st <= P_CMD;
    else        pkt_st <= pkt_nxt;
  end

  always_comb begin
    pkt_nxt = pkt_st;
    if (drop) pkt_nxt = P_CMD;
    else if (accept) begin
      case (pkt_st)
        P_CMD: pkt_nxt = P_AH;
        P_AH:  pkt_nxt = P_AL;
        P_AL:  pkt_nxt = P_DAT;
        P_DAT: pkt_nxt = P_CMD;
      endcase
    end else if (to_hit) pkt_nxt = P_CMD;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                           to_cnt <= '0;
    else if (start_det || !to_run || to_hit) to_cnt <= '0;
    else                                  to_cnt <= to_cnt + TW'(1);
  end

  // ---- packet storage and registered outputs ----
  logic [7:0] cmd_q, ah_q, al_q;
  wr_req_t    wr_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      ah_q        <= '0;
      al_q        <= '0;
      wr_q        <= '0;
      reg_wr      <= 1'b0;
      rx_byte_vld <= 1'b0;
      rx_byte     <= '0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_cmd     <= 1'b0;
    end else begin
      rx_byte_vld <= accept;
      err_frame   <= ferr;
      err_parity  <= perr;
      reg_wr      <= 1'b0;
      err_cmd     <= 1'b0;
      if (accept) begin
        rx_byte <= shift;
        case (pkt_st)
          P_CMD: cmd_q <= shift;
          P_AH:  ah_q  <= shift;
          P_AL:  al_q  <= shift;
          P_DAT: begin
            if (cmd_q == CMD_WR) begin
              reg_wr <= 1'b1;
              wr_q   <= '{addr: {ah_q, al_q}, data: shift};
            end else begin
              err_cmd <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign reg_addr  = wr_q.addr;
  assign reg_wdata = wr_q.data;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed vector table, hand-written break/glitch/reset sequences,
// then random frames predicted by a byte-queue packet model.
module tb_uart_cmd_rx;
  localparam int         BD  = 16;
  localparam int         TO  = 300;
  localparam logic [7:0] CMD = 8'hB0;
  localparam int         G   = 20;
  localparam int         L   = TO + 100;
`ifdef PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk_sys, rst_n, uart_rx;
  logic        reg_wr, rx_byte_vld, err_frame, err_parity, err_cmd;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, rx_byte;

  uart_cmd_rx #(.BAUD_DIV(BD), .TIMEOUT(TO), .CMD_WR(CMD)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .uart_rx(uart_rx),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .rx_byte_vld(rx_byte_vld), .rx_byte(rx_byte),
    .err_frame(err_frame), .err_parity(err_parity), .err_cmd(err_cmd)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  d;
    bit          stop;
    bit          pflip;
    int          gap;
    bit          e_vld, e_ferr, e_perr, e_wr, e_cmd;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] mq[$];
  int         applied = 0;
  int         miscomp = 0;

  // Pulse counters, sampled on the falling edge.
  int          n_vld = 0, n_ferr = 0, n_perr = 0, n_wr = 0, n_cmd = 0, n_coinc = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_data = '0, last_byte = '0;

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (rx_byte_vld) begin
        n_vld     <= n_vld + 1;
        last_byte <= rx_byte;
      end
      if (err_frame)  n_ferr <= n_ferr + 1;
      if (err_parity) n_perr <= n_perr + 1;
      if (err_cmd)    n_cmd  <= n_cmd + 1;
      if (reg_wr) begin
        n_wr      <= n_wr + 1;
        last_addr <= reg_addr;
        last_data <= reg_wdata;
        if (!rx_byte_vld) n_coinc <= n_coinc + 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    applied++;
    if (act != exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip);
    uart_rx = 1'b0;
    cyc(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      cyc(BD);
    end
    uart_rx = (^d) ^ pflip;
    cyc(BD);
    uart_rx = stop;
    cyc(BD);
    uart_rx = 1'b1;
  endtask

  task automatic add(input logic [7:0] d, input bit stop, input bit pflip, input int gap,
                     input bit vld, input bit fe, input bit pe, input bit wr, input bit ce,
                     input logic [15:0] a, input logic [7:0] wd);
    vec_t v;
    v.d = d; v.stop = stop; v.pflip = pflip; v.gap = gap;
    v.e_vld = vld; v.e_ferr = fe; v.e_perr = pe; v.e_wr = wr; v.e_cmd = ce;
    v.e_addr = a; v.e_data = wd;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int b_vld, b_f, b_p, b_w, b_c;
    b_vld = n_vld; b_f = n_ferr; b_p = n_perr; b_w = n_wr; b_c = n_cmd;
    send_frame(v.d, v.stop, v.pflip);
    cyc(v.gap);
    chk({tag, "/vld"},   n_vld - b_vld, v.e_vld);
    chk({tag, "/ferr"},  n_ferr - b_f,  v.e_ferr);
    chk({tag, "/perr"},  n_perr - b_p,  v.e_perr);
    chk({tag, "/wr"},    n_wr - b_w,    v.e_wr);
    chk({tag, "/cmd"},   n_cmd - b_c,   v.e_cmd);
    if (v.e_vld) chk({tag, "/byte"}, last_byte, v.d);
    if (v.e_wr) begin
      chk({tag, "/addr"}, last_addr, v.e_addr);
      chk({tag, "/data"}, last_data, v.e_data);
    end
  endtask

  // Packet-level model: accepted bytes queue up, four make a packet; errors and long idle flush.
  function automatic vec_t predict(input vec_t vi);
    vec_t v;
    bit   bad_par;
    v = vi;
    bad_par = PAR && v.pflip;
    v.e_ferr = !v.stop; v.e_perr = bad_par;
    v.e_vld = 0; v.e_wr = 0; v.e_cmd = 0; v.e_addr = '0; v.e_data = '0;
    if (!v.stop || bad_par) mq.delete();
    else begin
      v.e_vld = 1;
      mq.push_back(v.d);
      if (mq.size() == 4) begin
        if (mq[0] == CMD) begin
          v.e_wr = 1; v.e_addr = {mq[1], mq[2]}; v.e_data = mq[3];
        end else v.e_cmd = 1;
        mq.delete();
      end
    end
    if (v.gap > TO) mq.delete();
    return v;
  endfunction

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
    send_frame(b0, 1, 0); cyc(G);
    send_frame(b1, 1, 0); cyc(G);
    send_frame(b2, 1, 0); cyc(G);
    send_frame(b3, 1, 0); cyc(G);
  endtask

  initial begin
    int b_vld, b_f, b_p, b_w, b_c;
    vec_t v;

    // plain write
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h00,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h30,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h01,1,0,G, 1,0,0,1,0, 16'h0030,8'h01);
    // bad command, then good write
    add(8'hA5,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h12,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h34,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h56,1,0,G, 1,0,0,0,1, 16'h0,8'h0);
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h12,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h34,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h56,1,0,G, 1,0,0,1,0, 16'h1234,8'h56);
    // framing error discards the partial packet
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h00,0,0,G, 0,1,0,0,0, 16'h0,8'h0);
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h00,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h30,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h01,1,0,G, 1,0,0,1,0, 16'h0030,8'h01);
    // timeouts flush B0,00 and then 30,01
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h00,1,0,L, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h30,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h01,1,0,L, 1,0,0,0,0, 16'h0,8'h0);
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h00,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h40,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h02,1,0,G, 1,0,0,1,0, 16'h0040,8'h02);
    // parity flipped on addr_l
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h00,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h30,1,1,G, !PAR,0,PAR,0,0, 16'h0,8'h0);
    add(8'h01,1,0,L, 1,0,0,!PAR,0, 16'h0030,8'h01);
    // stop low and parity bad together
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'h7E,0,1,G, 0,1,PAR,0,0, 16'h0,8'h0);
    // all-ones boundary packet
    add(8'hB0,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'hFF,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'hFF,1,0,G, 1,0,0,0,0, 16'h0,8'h0);
    add(8'hFF,1,0,G, 1,0,0,1,0, 16'hFFFF,8'hFF);

    rst_n = 1'b0;
    uart_rx = 1'b1;
    cyc(4);
    chk("rst/reg_wr", reg_wr, 0);
    chk("rst/reg_addr", reg_addr, 0);
    chk("rst/reg_wdata", reg_wdata, 0);
    chk("rst/flags", {rx_byte_vld, err_frame, err_parity, err_cmd}, 0);
    chk("rst/rx_byte", rx_byte, 0);
    rst_n = 1'b1;
    cyc(4);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("t%0d", i));

    // glitch of BD/4 cycles on an idle line
    b_vld = n_vld; b_f = n_ferr; b_p = n_perr;
    uart_rx = 1'b0; cyc(BD / 4);
    uart_rx = 1'b1; cyc(3 * BD);
    chk("glitch/vld", n_vld - b_vld, 0);
    chk("glitch/err", (n_ferr - b_f) + (n_perr - b_p), 0);

    // held-low break after one byte: single frame error, packet flushed
    send_frame(8'hB0, 1, 0); cyc(G);
    b_f = n_ferr; b_vld = n_vld;
    uart_rx = 1'b0; cyc(30 * BD);
    uart_rx = 1'b1; cyc(2 * BD);
    chk("break/ferr", n_ferr - b_f, 1);
    chk("break/vld", n_vld - b_vld, 0);
    b_w = n_wr;
    send_pkt(8'hB0, 8'h11, 8'h22, 8'h33);
    chk("break/wr", n_wr - b_w, 1);
    chk("break/addr", last_addr, 16'h1122);
    chk("break/data", last_data, 8'h33);

    // reset mid-byte with a partial packet pending
    send_frame(8'hB0, 1, 0); cyc(G);
    uart_rx = 1'b0; cyc(BD);
    uart_rx = 1'b1; cyc(2 * BD);
    uart_rx = 1'b0; cyc(BD / 2);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    cyc(3);
    chk("mrst/reg_wr", reg_wr, 0);
    chk("mrst/reg_addr", reg_addr, 0);
    chk("mrst/reg_wdata", reg_wdata, 0);
    chk("mrst/flags", {rx_byte_vld, err_frame, err_parity, err_cmd, rx_byte}, 0);
    rst_n = 1'b1;
    cyc(5);
    b_vld = n_vld; b_w = n_wr; b_c = n_cmd;
    send_pkt(8'hB0, 8'hAB, 8'hCD, 8'hEF);
    chk("mrst/vld", n_vld - b_vld, 4);
    chk("mrst/wr", n_wr - b_w, 1);
    chk("mrst/cmd", n_cmd - b_c, 0);
    chk("mrst/addr", last_addr, 16'hABCD);
    chk("mrst/data", last_data, 8'hEF);

    // random frames against the packet model (DUT is in P_CMD here)
    mq.delete();
    for (int i = 0; i < 60; i++) begin
      v.d     = ($urandom_range(0, 2) == 0) ? CMD : 8'($urandom);
      v.stop  = ($urandom_range(0, 11) != 0);
      v.pflip = ($urandom_range(0, 9) == 0);
      v.gap   = ($urandom_range(0, 11) == 0) ? L : int'($urandom_range(2, 60));
      apply(predict(v), $sformatf("r%0d", i));
    end

    chk("wr_with_vld", n_coinc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
    $finish;
  end
endmodule
